jtpopeye_sdram_arb: RTL and testbench

SDRAM read arbiter that shares the single SDRAM read port between the main CPU ROM fetch (32 kB, byte wide) and the OBJ graphics ROM fetch (32 kB, 32-bit words). It sits between `jtpopeye_main` / `jtpopeye_video` and the SDRAM controller. It sequences one outstanding request at a time, arbitrates round-robin between the two requesters, and gates refresh to idle slots. It also holds the main CPU in reset-ready until the ROM download has finished.

---
 rtl/jtpopeye_sdram_arb.sv | 147 ++++++++++++++
 tb/tb_jtpopeye_sdram_arb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_sdram_arb.sv
// Shares one SDRAM read port between main CPU ROM (bytes) and OBJ ROM (32-bit words).
// Define JTPOPEYE_MAIN_CACHE_EN to keep the main word as a one-line cache across CPU accesses.
module jtpopeye_sdram_arb #(
  parameter logic [21:0] OBJ_BASE = 22'h4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        loop_rst,
  input  logic        main_cs,
  input  logic [14:0] main_addr,
  output logic [7:0]  main_dout,
  output logic        main_ok,
  input  logic [12:0] obj_addr,
  output logic [31:0] obj_dout,
  output logic        obj_ok,
  output logic        ready,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        data_rdy,
  input  logic [31:0] data_read,
  output logic        refresh_en
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic [1:0]  rdy_pipe;
  logic        main_valid, obj_valid, last_obj, serve_obj;
  logic [12:0] main_tag, obj_tag, lat_tag;
  logic [31:0] main_word, obj_word;
  logic        main_vld_eff, main_hit, obj_hit;
  logic        main_pend, obj_pend, sel_obj, abort;
  logic [21:0] main_sd_addr, obj_sd_addr;

  assign abort = downloading | loop_rst;
  assign ready = rdy_pipe[1];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdy_pipe <= 2'b00;
    else        rdy_pipe <= {rdy_pipe[0], ~abort};

`ifdef JTPOPEYE_MAIN_CACHE_EN
  assign main_vld_eff = main_valid;
`else
  logic main_cs_d, main_rise;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) main_cs_d <= 1'b0;
    else        main_cs_d <= main_cs;

  // A new CPU access is treated as a miss from its first cycle on.
  assign main_rise    = main_cs & ~main_cs_d;
  assign main_vld_eff = main_valid & ~main_rise;
`endif

  assign main_hit  = main_vld_eff & (main_tag == main_addr[14:2]);
  assign obj_hit   = obj_valid & (obj_tag == obj_addr);
  assign main_ok   = main_cs & main_hit;
  assign obj_ok    = obj_hit;
  assign main_pend = ready & main_cs & ~main_hit;
  assign obj_pend  = ready & ~obj_hit;
  // Round-robin: OBJ takes a tie unless it was the last one served.
  assign sel_obj   = obj_pend & (~main_pend | ~last_obj);

  assign main_sd_addr = {8'd0, main_addr[14:2], 1'b0};
  assign obj_sd_addr  = OBJ_BASE + {8'd0, obj_addr, 1'b0};

  assign obj_dout   = obj_word;
  assign refresh_en = ready & (state == IDLE) & ~main_pend & ~obj_pend;

  always_comb begin
    main_dout = main_word[7:0];
    case (main_addr[1:0])
      2'd0: main_dout = main_word[7:0];
      2'd1: main_dout = main_word[15:8];
      2'd2: main_dout = main_word[23:16];
      2'd3: main_dout = main_word[31:24];
      default: main_dout = main_word[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= 22'd0;
      main_valid <= 1'b0;
      obj_valid  <= 1'b0;
      main_tag   <= 13'd0;
      obj_tag    <= 13'd0;
      lat_tag    <= 13'd0;
      main_word  <= 32'd0;
      obj_word   <= 32'd0;
      last_obj   <= 1'b0;
      serve_obj  <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      main_valid <= 1'b0;
      obj_valid  <= 1'b0;
    end else begin
`ifndef JTPOPEYE_MAIN_CACHE_EN
      if (main_rise) main_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (main_pend | obj_pend) begin
            serve_obj  <= sel_obj;
            sdram_addr <= sel_obj ? obj_sd_addr : main_sd_addr;
            lat_tag    <= sel_obj ? obj_addr : main_addr[14:2];
            sdram_req  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // Tag records the latched address, so a moved address simply re-pends.
          if (data_rdy) begin
            if (serve_obj) begin
              obj_word  <= data_read;
              obj_tag   <= lat_tag;
              obj_valid <= 1'b1;
            end else begin
              main_word  <= data_read;
              main_tag   <= lat_tag;
              main_valid <= 1'b1;
            end
            last_obj <= serve_obj;
            state    <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          sdram_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtpopeye_sdram_arb.sv
// Directed bench for jtpopeye_sdram_arb: the bench plays the SDRAM controller by hand.
module tb_jtpopeye_sdram_arb;

  logic        clk = 1'b0;
  logic        rst_n, downloading, loop_rst;
  logic        main_cs;
  logic [14:0] main_addr;
  logic [7:0]  main_dout;
  logic        main_ok;
  logic [12:0] obj_addr;
  logic [31:0] obj_dout;
  logic        obj_ok, ready, sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack, data_rdy;
  logic [31:0] data_read;
  logic        refresh_en;

  int n_cmp = 0;
  int n_err = 0;

  jtpopeye_sdram_arb dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .loop_rst(loop_rst),
    .main_cs(main_cs), .main_addr(main_addr), .main_dout(main_dout), .main_ok(main_ok),
    .obj_addr(obj_addr), .obj_dout(obj_dout), .obj_ok(obj_ok), .ready(ready),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tg, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [21:0] a, input string tg);
    int n = 0;
    while (!sdram_req && n < 16) begin
      tick();
      n++;
    end
    chk({tg, "_req"}, 32'(sdram_req), 32'd1);
    chk({tg, "_addr"}, 32'(sdram_addr), 32'(a));
  endtask

  task automatic do_ack(input string tg);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk({tg, "_req_drop"}, 32'(sdram_req), 32'd0);
  endtask

  task automatic do_data(input logic [31:0] d);
    data_rdy  = 1'b1;
    data_read = d;
    tick();
    data_rdy  = 1'b0;
  endtask

  task automatic serve(input logic [21:0] a, input logic [31:0] d, input string tg);
    wait_req(a, tg);
    tick();
    chk({tg, "_req_held"}, 32'(sdram_req), 32'd1);
    do_ack(tg);
    tick();
    do_data(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf;
    logic [31:0] w;
    rst_n = 1'b0; downloading = 1'b1; loop_rst = 1'b0;
    main_cs = 1'b1; main_addr = 15'h0005; obj_addr = 13'h0010;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = 32'd0;
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_req", 32'(sdram_req), 32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_oks", {30'd0, main_ok, obj_ok}, 32'd0);
    chk("rst_douts", {main_dout, obj_dout[23:0]} | 32'(obj_dout[31:24]), 32'd0);
    chk("rst_refresh", 32'(refresh_en), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("dl_ready", 32'(ready), 32'd0);
    downloading = 1'b0;
    tick();
    chk("ready_d1", 32'(ready), 32'd0);
    tick();
    chk("ready_d2", 32'(ready), 32'd1);
    chk("ready_noreq", 32'(sdram_req), 32'd0);
    chk("ready_norefresh", 32'(refresh_en), 32'd0);

    // Tie after reset: OBJ first, then main back-to-back.
    serve(22'h004020, 32'h11223344, "obj0");
    chk("obj0_ok", 32'(obj_ok), 32'd1);
    chk("obj0_dout", obj_dout, 32'h11223344);
    chk("obj0_main_ok", 32'(main_ok), 32'd0);
    chk("b2b_idle", 32'(sdram_req), 32'd0);
    tick();
    chk("b2b_req", 32'(sdram_req), 32'd1);
    serve(22'h000002, 32'hDDCCBBAA, "main0");
    chk("main0_ok", 32'(main_ok), 32'd1);
    chk("main0_dout", 32'(main_dout), 32'hBB);
    main_addr = 15'h0004; #1;
    chk("main0_b0", 32'(main_dout), 32'hAA);
    main_addr = 15'h0007; #1;
    chk("main0_b3", 32'(main_dout), 32'hDD);
    chk("refresh_idle", 32'(refresh_en), 32'd1);

    // OBJ alone, then a tie where main must win.
    obj_addr = 13'h0011;
    serve(22'h004022, 32'h55667788, "obj1");
    chk("obj1_dout", obj_dout, 32'h55667788);
    main_addr = 15'h0100; obj_addr = 13'h1FFF;
    serve(22'h000080, 32'h0A0B0C0D, "tie_main");
    chk("tie_main_dout", 32'(main_dout), 32'h0D);
    serve(22'h007FFE, 32'hCAFEF00D, "tie_obj");
    chk("tie_obj_dout", obj_dout, 32'hCAFEF00D);
    chk("tie_obj_ok", 32'(obj_ok), 32'd1);

    // Byte walk with main_cs toggling between accesses.
    main_cs = 1'b0; main_addr = 15'h0004; #1;
    chk("cs_low_ok", 32'(main_ok), 32'd0);
    nf = 0;
    for (int i = 0; i < 4; i++) begin
      main_addr = 15'(4 + i);
      main_cs = 1'b1;
      tick();
      if (sdram_req) begin
        nf++;
        serve(22'h000002, 32'hDDCCBBAA, "walk");
      end
      w = 32'hDDCCBBAA >> (8 * i);
      chk("walk_ok", 32'(main_ok), 32'd1);
      chk("walk_dout", 32'(main_dout), 32'(w[7:0]));
      if (i < 3) begin
        main_cs = 1'b0;
        tick();
        chk("walk_cs_low", 32'(main_ok), 32'd0);
      end
    end
`ifdef JTPOPEYE_MAIN_CACHE_EN
    chk("walk_fetches", 32'(nf), 32'd1);
`else
    chk("walk_fetches", 32'(nf), 32'd4);
`endif

    // Download during WAIT aborts; late data_rdy is dropped; refetch after ready.
    obj_addr = 13'h0020;
    wait_req(22'h004040, "abt");
    do_ack("abt");
    tick();
    downloading = 1'b1;
    tick();
    chk("abt_req", 32'(sdram_req), 32'd0);
    chk("abt_oks", {30'd0, main_ok, obj_ok}, 32'd0);
    do_data(32'hBAD0BAD0);
    chk("abt_late_dout", obj_dout, 32'hCAFEF00D);
    chk("abt_late_ok", 32'(obj_ok), 32'd0);
    downloading = 1'b0;
    tick();
    chk("abt_ready_lo", 32'(ready), 32'd0);
    tick();
    chk("abt_ready_hi", 32'(ready), 32'd1);
    serve(22'h004040, 32'h01020304, "refetch_obj");
    chk("refetch_obj_ok", 32'(obj_ok), 32'd1);
    serve(22'h000002, 32'hDDCCBBAA, "refetch_main");
    chk("refetch_main_ok", 32'(main_ok), 32'd1);
    chk("refetch_main_dout", 32'(main_dout), 32'hDD);

    // OBJ address moves during WAIT.
    obj_addr = 13'h0030;
    wait_req(22'h004060, "mv");
    tick();
    do_ack("mv");
    tick();
    obj_addr = 13'h0031;
    do_data(32'h11111111);
    chk("mv_stale_ok", 32'(obj_ok), 32'd0);
    serve(22'h004062, 32'h22222222, "mv2");
    chk("mv2_ok", 32'(obj_ok), 32'd1);
    chk("mv2_dout", obj_dout, 32'h22222222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
